// File: rtl/axi_cache_refill_ctrl.sv
// ============================================================================
//  Module   : axi_cache_refill_ctrl
//  Purpose  : Critical-word-first AXI4 WRAP line refill for the cache.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module axi_cache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [ADDR_W-1:0]            miss_addr,
    output logic                         crit_valid,
    output logic [DATA_W-1:0]            crit_data,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [LINE_BEATS*DATA_W-1:0] fill_line,
    output logic                         fill_err,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [ADDR_W-1:0]            araddr,
    output logic [7:0]                   arlen,
    output logic [1:0]                   arburst,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast
);

    localparam int BYTE_OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W      = $clog2(LINE_BEATS);
    localparam int LINE_BYTES = LINE_BEATS * DATA_W / 8;

    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(DATA_W / 8 - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_CNT  = IDX_W'(LINE_BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_FILL = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic                         miss_ready_q, miss_ready_d;
    logic                         arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic                         crit_valid_q, crit_valid_d;
    logic                         fill_valid_q, fill_valid_d;
    logic                         fill_err_q, fill_err_d;
    logic                         err_q, err_d;
    logic [ADDR_W-1:0]            araddr_q, araddr_d;
    logic [ADDR_W-1:0]            fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]            crit_data_q, crit_data_d;
    logic [LINE_BEATS*DATA_W-1:0] line_q, line_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [IDX_W-1:0]             cnt_q, cnt_d;

    logic w_accept;
    logic w_beat;
    logic w_last_cnt;
    logic w_burst_end;
    logic unused_rresp;

    assign w_accept    = (state_q == S_IDLE) && miss_valid && miss_ready_q;
    assign w_beat      = (state_q == S_DATA) && rvalid && rready_q;
    assign w_last_cnt  = (cnt_q == LAST_CNT);
    assign w_burst_end = w_beat && (w_last_cnt || rlast);
    assign unused_rresp = rresp[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept)    state_d = S_ADDR;
            S_ADDR:  if (arready)     state_d = S_DATA;
            S_DATA:  if (w_burst_end) state_d = S_FILL;
            S_FILL:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered from these
    always_comb begin
        miss_ready_d = (state_d == S_IDLE);
        arvalid_d    = (state_d == S_ADDR);
        rready_d     = (state_d == S_DATA);
        fill_valid_d = (state_d == S_FILL);
        crit_valid_d = w_beat && (cnt_q == '0);
        araddr_d     = araddr_q;
        fill_addr_d  = fill_addr_q;
        fill_err_d   = fill_err_q;
        crit_data_d  = crit_data_q;
        line_d       = line_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        if (w_accept) begin
            araddr_d    = miss_addr & ~WORD_MASK;
            fill_addr_d = miss_addr & ~LINE_MASK;
            idx_d       = miss_addr[BYTE_OFF +: IDX_W];
            cnt_d       = '0;
            err_d       = 1'b0;
        end

        if (w_beat) begin
            line_d[idx_q*DATA_W +: DATA_W] = rdata;
            idx_d = idx_q + 1'b1;
            if (!w_last_cnt) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == '0) begin
                crit_data_d = rdata;
            end
            // An early rlast truncates the line; a missing final rlast is tolerated
            if (rresp[1] || (rlast && !w_last_cnt)) begin
                err_d = 1'b1;
            end
        end

        if (w_burst_end) begin
            fill_err_d = err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_ready_q <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            crit_valid_q <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            err_q        <= 1'b0;
            araddr_q     <= '0;
            fill_addr_q  <= '0;
            crit_data_q  <= '0;
            line_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
        end else begin
            miss_ready_q <= miss_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            crit_valid_q <= crit_valid_d;
            fill_valid_q <= fill_valid_d;
            fill_err_q   <= fill_err_d;
            err_q        <= err_d;
            araddr_q     <= araddr_d;
            fill_addr_q  <= fill_addr_d;
            crit_data_q  <= crit_data_d;
            line_q       <= line_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
        end
    end

    assign miss_ready = miss_ready_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign fill_valid = fill_valid_q;
    assign fill_addr  = fill_addr_q;
    assign fill_line  = line_q;
    assign fill_err   = fill_err_q;
    assign araddr     = araddr_q;
    assign arlen      = 8'(LINE_BEATS - 1);
    assign arburst    = 2'b10;

endmodule

`default_nettype wire

// File: tb/tb_axi_cache_refill_ctrl.sv
// ============================================================================
//  Module   : tb_axi_cache_refill_ctrl
//  Purpose  : Directed self-checking bench for axi_cache_refill_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_cache_refill_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_BEATS = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         miss_valid = 1'b0;
    logic                         miss_ready;
    logic [ADDR_W-1:0]            miss_addr = '0;
    logic                         crit_valid;
    logic [DATA_W-1:0]            crit_data;
    logic                         fill_valid;
    logic [ADDR_W-1:0]            fill_addr;
    logic [LINE_BEATS*DATA_W-1:0] fill_line;
    logic                         fill_err;
    logic                         arvalid;
    logic                         arready = 1'b0;
    logic [ADDR_W-1:0]            araddr;
    logic [7:0]                   arlen;
    logic [1:0]                   arburst;
    logic                         rvalid = 1'b0;
    logic                         rready;
    logic [DATA_W-1:0]            rdata = '0;
    logic [1:0]                   rresp = 2'b00;
    logic                         rlast = 1'b0;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int acc    = 0;

    axi_cache_refill_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BEATS(LINE_BEATS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
        .fill_err(fill_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] addr, input logic hold);
        miss_valid = 1'b1;
        miss_addr  = addr;
        acc        = cyc;
        step();
        miss_valid = hold;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        step();
        rvalid = 1'b0;
        rresp  = 2'b00;
        rlast  = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_crit_valid", crit_valid, 0);
        chk("rst_arlen", arlen, 3);
        chk("rst_arburst", arburst, 2);
        chk("rst_araddr", araddr, 0);
        rst_n = 1'b1;
        step();

        // Critical-word-first refill at 0x1008 with minimum latency
        arready = 1'b1;
        accept(32'h1008, 1'b0);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1008);
        chk("t1_arlen", arlen, 3);
        chk("t1_miss_ready", miss_ready, 0);
        chk("t1_rready_pre", rready, 0);
        step();
        chk("t1_rready", rready, 1);
        chk("t1_arvalid_drop", arvalid, 0);
        beat(32'hAAAA_0001, 2'b00, 1'b0);
        chk("t1_crit_valid", crit_valid, 1);
        chk("t1_crit_data", crit_data, 32'hAAAA_0001);
        beat(32'hBBBB_0002, 2'b00, 1'b0);
        chk("t1_crit_pulse", crit_valid, 0);
        beat(32'hCCCC_0003, 2'b00, 1'b0);
        beat(32'hDDDD_0004, 2'b00, 1'b1);
        chk("t1_fill_valid", fill_valid, 1);
        chk("t1_latency", cyc - acc, 6);
        chk("t1_fill_addr", fill_addr, 32'h1000);
        chk("t1_fill_line", fill_line,
            {32'hBBBB_0002, 32'hAAAA_0001, 32'hDDDD_0004, 32'hCCCC_0003});
        chk("t1_fill_err", fill_err, 0);
        chk("t1_rready_end", rready, 0);
        step();
        chk("t1_fill_pulse", fill_valid, 0);
        chk("t1_miss_ready_back", miss_ready, 1);

        // AR stalled for five cycles
        arready = 1'b0;
        accept(32'h2000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_arvalid_hold", arvalid, 1);
            chk("t2_araddr_hold", araddr, 32'h2000);
            chk("t2_rready_low", rready, 0);
            step();
        end
        arready = 1'b1;
        chk("t2_arvalid_last", arvalid, 1);
        step();
        chk("t2_rready", rready, 1);
        beat(32'h2222_0000, 2'b00, 1'b0);
        beat(32'h2222_0001, 2'b00, 1'b0);
        beat(32'h2222_0002, 2'b00, 1'b0);
        beat(32'h2222_0003, 2'b00, 1'b1);
        chk("t2_fill_valid", fill_valid, 1);
        chk("t2_fill_line", fill_line,
            {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000});
        chk("t2_fill_addr", fill_addr, 32'h2000);
        chk("t2_fill_err", fill_err, 0);
        step();

        // SLVERR on the second beat poisons the line but the burst completes
        accept(32'h3004, 1'b0);
        step();
        beat(32'hE000_0000, 2'b00, 1'b0);
        beat(32'hE000_0001, 2'b10, 1'b0);
        chk("t3_rready_after_err", rready, 1);
        chk("t3_no_early_fill", fill_valid, 0);
        beat(32'hE000_0002, 2'b00, 1'b0);
        beat(32'hE000_0003, 2'b00, 1'b1);
        chk("t3_fill_valid", fill_valid, 1);
        chk("t3_fill_err", fill_err, 1);
        chk("t3_fill_addr", fill_addr, 32'h3000);
        chk("t3_fill_line", fill_line,
            {32'hE000_0002, 32'hE000_0001, 32'hE000_0000, 32'hE000_0003});
        step();
        chk("t3_fill_once", fill_valid, 0);

        // Early rlast on the second beat; upper slots keep stale data
        accept(32'h4000, 1'b0);
        step();
        beat(32'hF000_0000, 2'b00, 1'b0);
        beat(32'hF000_0001, 2'b00, 1'b1);
        chk("t4_fill_valid", fill_valid, 1);
        chk("t4_fill_err", fill_err, 1);
        chk("t4_rready_low", rready, 0);
        chk("t4_fill_line", fill_line,
            {32'hE000_0002, 32'hE000_0001, 32'hF000_0001, 32'hF000_0000});
        step();
        chk("t4_rready_after", rready, 0);
        chk("t4_fill_pulse", fill_valid, 0);
        chk("t4_miss_ready", miss_ready, 1);

        // Gapped R beats with miss_valid held high throughout
        accept(32'h5008, 1'b1);
        miss_addr = 32'h6000;
        step();
        for (int k = 0; k < 4; k++) begin
            beat(32'h5555_0000 + 32'(k), 2'b00, k == 3);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    chk("t5_miss_ready_busy", miss_ready, 0);
                    chk("t5_no_second_ar", arvalid, 0);
                    step();
                end
            end
        end
        chk("t5_fill_valid", fill_valid, 1);
        chk("t5_miss_ready_fill", miss_ready, 0);
        chk("t5_fill_line", fill_line,
            {32'h5555_0001, 32'h5555_0000, 32'h5555_0003, 32'h5555_0002});
        step();
        chk("t5_miss_ready_idle", miss_ready, 1);
        chk("t5_idle_arvalid", arvalid, 0);
        step();
        miss_valid = 1'b0;
        chk("t5_next_arvalid", arvalid, 1);
        chk("t5_next_araddr", araddr, 32'h6000);

        // Asynchronous reset in the middle of the second R beat
        step();
        beat(32'h6666_0000, 2'b00, 1'b0);
        rvalid = 1'b1;
        rdata  = 32'h6666_0001;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rready_async", rready, 0);
        chk("t6_miss_ready_async", miss_ready, 1);
        chk("t6_arvalid_async", arvalid, 0);
        chk("t6_crit_async", crit_valid, 0);
        rvalid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_fill", fill_valid, 0);
            chk("t6_no_crit", crit_valid, 0);
        end

        // Fresh miss after reset, critical word in the last slot
        accept(32'h700C, 1'b0);
        chk("t7_araddr", araddr, 32'h700C);
        step();
        beat(32'h7777_0000, 2'b00, 1'b0);
        chk("t7_crit_data", crit_data, 32'h7777_0000);
        beat(32'h7777_0001, 2'b00, 1'b0);
        beat(32'h7777_0002, 2'b00, 1'b0);
        beat(32'h7777_0003, 2'b00, 1'b1);
        chk("t7_fill_valid", fill_valid, 1);
        chk("t7_latency", cyc - acc, 6);
        chk("t7_fill_addr", fill_addr, 32'h7000);
        chk("t7_fill_err", fill_err, 0);
        chk("t7_fill_line", fill_line,
            {32'h7777_0000, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001});
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
